// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 add/multiply unit: field layout,
// constants, operation encodings and the leading-zero counter.
package fp_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    localparam logic FP_ADD = 1'b0;
    localparam logic FP_MUL = 1'b1;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } fp32_t;

    // Returns 24 for an all-zero input so the normalizer shifts everything out.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational binary32 adder: flush-to-zero inputs, truncating alignment
// and normalization, signed infinity on overflow.
module fp_add
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    fp32_t x, z, big, sml;
    logic [7:0]        diff;
    logic [23:0]       mb, ms, norm;
    logic [24:0]       sum;
    logic [4:0]        lz;
    logic [22:0]       frac;
    logic signed [9:0] e;
    logic x_zero, z_zero, x_inf, z_inf, any_nan;

    assign x = a;
    assign z = b;
    assign x_zero  = (x.exp == 8'h00);
    assign z_zero  = (z.exp == 8'h00);
    assign x_inf   = (x.exp == EXP_MAX) && (x.frac == 23'h0);
    assign z_inf   = (z.exp == EXP_MAX) && (z.frac == 23'h0);
    assign any_nan = ((x.exp == EXP_MAX) && (x.frac != 23'h0)) ||
                     ((z.exp == EXP_MAX) && (z.frac != 23'h0));

    always_comb begin
        big = x;
        sml = z;
        if ({z.exp, z.frac} > {x.exp, x.frac}) begin
            big = z;
            sml = x;
        end
        diff = big.exp - sml.exp;
        mb   = {1'b1, big.frac};
        ms   = {1'b1, sml.frac} >> diff;
        if (big.sign == sml.sign)
            sum = {1'b0, mb} + {1'b0, ms};
        else
            sum = {1'b0, mb} - {1'b0, ms};
        lz   = lzc24(sum[23:0]);
        norm = sum[23:0] << lz;
        if (sum[24]) begin
            e    = $signed({2'b00, big.exp}) + 10'sd1;
            frac = sum[23:1];
        end else begin
            e    = $signed({2'b00, big.exp}) - $signed({5'b00000, lz});
            frac = norm[22:0];
        end

        if (any_nan)
            y = QNAN;
        else if (x_inf && z_inf && (x.sign != z.sign))
            y = QNAN;
        else if (x_inf)
            y = {x.sign, EXP_MAX, 23'h0};
        else if (z_inf)
            y = {z.sign, EXP_MAX, 23'h0};
        else if (x_zero)
            y = z_zero ? {x.sign & z.sign, 31'h0} : b;
        else if (z_zero)
            y = a;
        else if (!sum[24] && !norm[23])
            y = 32'h0000_0000;
        else if (e >= 10'sd255)
            y = {big.sign, EXP_MAX, 23'h0};
        else if (e <= 10'sd0)
            y = {big.sign, 31'h0};
        else
            y = {big.sign, e[7:0], frac};
    end

endmodule

// File: rtl/fp_mul.sv
// Combinational binary32 multiplier: flush-to-zero inputs, truncated
// 24-bit product, signed infinity/zero on exponent overflow/underflow.
module fp_mul
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    fp32_t x, z;
    logic              sign;
    logic [24:0]       top;
    logic [22:0]       frac;
    logic signed [9:0] e;
    logic x_zero, z_zero, x_inf, z_inf, any_nan;

    assign x = a;
    assign z = b;
    assign sign    = x.sign ^ z.sign;
    assign x_zero  = (x.exp == 8'h00);
    assign z_zero  = (z.exp == 8'h00);
    assign x_inf   = (x.exp == EXP_MAX) && (x.frac == 23'h0);
    assign z_inf   = (z.exp == EXP_MAX) && (z.frac == 23'h0);
    assign any_nan = ((x.exp == EXP_MAX) && (x.frac != 23'h0)) ||
                     ((z.exp == EXP_MAX) && (z.frac != 23'h0));

    always_comb begin
        // Only product bits [47:23] can reach the truncated result.
        top  = 25'(({24'h0, 1'b1, x.frac} * {24'h0, 1'b1, z.frac}) >> 23);
        frac = top[24] ? top[23:1] : top[22:0];
        e    = $signed({2'b00, x.exp}) + $signed({2'b00, z.exp})
             - $signed(10'(EXP_BIAS)) + (top[24] ? 10'sd1 : 10'sd0);

        if (any_nan)
            y = QNAN;
        else if ((x_inf && z_zero) || (z_inf && x_zero))
            y = QNAN;
        else if (x_inf || z_inf)
            y = {sign, EXP_MAX, 23'h0};
        else if (x_zero || z_zero)
            y = {sign, 31'h0};
        else if (e >= 10'sd255)
            y = {sign, EXP_MAX, 23'h0};
        else if (e <= 10'sd0)
            y = {sign, 31'h0};
        else
            y = {sign, e[7:0], frac};
    end

endmodule

// File: rtl/fp_alu.sv
// Binary32 add/multiply unit: combinational Result for same-cycle use and a
// registered Result_q for multicycle sequencing.
module fp_alu
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ALUControl,
    output logic [31:0] Result,
    output logic [31:0] Result_q
);
    logic [31:0] add_y, mul_y;

    fp_add u_add (.a(a), .b(b), .y(add_y));
    fp_mul u_mul (.a(a), .b(b), .y(mul_y));

    assign Result = (ALUControl == FP_MUL) ? mul_y : add_y;

    always_ff @(posedge clk) begin
        if (reset)
            Result_q <= 32'h0000_0000;
        else
            Result_q <= Result;
    end

endmodule

// File: tb/tb_fp_alu.sv
// Directed-vector bench for fp_alu: combinational results for add, multiply
// and special cases, plus reset and back-to-back behaviour of Result_q.
module tb_fp_alu;

    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic        ALUControl;
    logic [31:0] Result, Result_q;

    int n_checks = 0;
    int n_fail   = 0;

    fp_alu dut (
        .clk(clk),
        .reset(reset),
        .a(a),
        .b(b),
        .ALUControl(ALUControl),
        .Result(Result),
        .Result_q(Result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ALUControl = 1'b0; a = 32'h3F80_0000; b = 32'h3F80_0000;
        @(posedge clk); #1;
        n_checks++;
        if (Result_q !== 32'h0000_0000) begin
            n_fail++; $display("FAIL reset_q: Result_q=%08h expected 00000000", Result_q);
        end
        n_checks++;
        if (Result !== 32'h4000_0000) begin
            n_fail++; $display("FAIL reset_comb: Result=%08h expected 40000000", Result);
        end
        @(posedge clk); #1;
        n_checks++;
        if (Result_q !== 32'h0000_0000) begin
            n_fail++; $display("FAIL reset_hold: Result_q=%08h expected 00000000", Result_q);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (Result_q !== 32'h4000_0000) begin
            n_fail++; $display("FAIL reset_release: Result_q=%08h expected 40000000", Result_q);
        end
        ALUControl = 1'b1; a = 32'h3FC0_0000; b = 32'h4000_0000;
        #1;
        n_checks++;
        if (Result !== 32'h4040_0000 || Result_q !== 32'h4000_0000) begin
            n_fail++; $display("FAIL pre_edge: Result=%08h Result_q=%08h expected 40400000/40000000", Result, Result_q);
        end
        @(posedge clk); #1;
        n_checks++;
        if (Result_q !== 32'h4040_0000) begin
            n_fail++; $display("FAIL post_edge: Result_q=%08h expected 40400000", Result_q);
        end
    endtask

    task automatic test_add();
        logic [31:0] va [10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000,
                                 32'h0000_0000, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF};
        logic [31:0] vb [10] = '{32'h3F80_0000, 32'hBF00_0000, 32'hC040_0000, 32'hC000_0000, 32'h4000_0000,
                                 32'h3FC0_0000, 32'h3F80_0000, 32'h3380_0000, 32'h3440_0000, 32'h7F7F_FFFF};
        logic [31:0] vy [10] = '{32'h4000_0000, 32'h3FC0_0000, 32'h0000_0000, 32'hBF80_0000, 32'h40A0_0000,
                                 32'h3FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h7F80_0000};
        ALUControl = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = va[i]; b = vb[i];
            #2;
            n_checks++;
            if (Result !== vy[i]) begin
                n_fail++;
                $display("FAIL add[%0d] %08h+%08h: Result=%08h expected %08h", i, va[i], vb[i], Result, vy[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] va [7] = '{32'h3FC0_0000, 32'h4040_0000, 32'h7F00_0000, 32'h0080_0000,
                                32'h0000_0000, 32'h3F80_0000, 32'h3FFF_FFFF};
        logic [31:0] vb [7] = '{32'h4000_0000, 32'hC000_0000, 32'h7F00_0000, 32'h0080_0000,
                                32'hBF80_0000, 32'h3F80_0000, 32'h3FFF_FFFF};
        logic [31:0] vy [7] = '{32'h4040_0000, 32'hC0C0_0000, 32'h7F80_0000, 32'h0000_0000,
                                32'h8000_0000, 32'h3F80_0000, 32'h407F_FFFE};
        ALUControl = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = va[i]; b = vb[i];
            #2;
            n_checks++;
            if (Result !== vy[i]) begin
                n_fail++;
                $display("FAIL mul[%0d] %08h*%08h: Result=%08h expected %08h", i, va[i], vb[i], Result, vy[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic        vc [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] va [7] = '{32'h0000_0000, 32'h7F80_0000, 32'h7F80_0001, 32'hFF80_0000,
                                32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0000};
        logic [31:0] vb [7] = '{32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000,
                                32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
        logic [31:0] vy [7] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
                                32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0000};
        for (int i = 0; i < 7; i++) begin
            ALUControl = vc[i]; a = va[i]; b = vb[i];
            #2;
            n_checks++;
            if (Result !== vy[i]) begin
                n_fail++;
                $display("FAIL special[%0d] op=%0d %08h,%08h: Result=%08h expected %08h",
                         i, vc[i], va[i], vb[i], Result, vy[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] vy [4] = '{32'h40A0_0000, 32'h40C0_0000, 32'h40A0_0000, 32'h40C0_0000};
        a = 32'h4040_0000; b = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ALUControl = vc[i];
            @(posedge clk); #1;
            n_checks++;
            if (Result_q !== vy[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d] op=%0d: Result_q=%08h expected %08h", i, vc[i], Result_q, vy[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (Result_q !== 32'h0000_0000 || Result !== 32'h40C0_0000) begin
            n_fail++;
            $display("FAIL b2b_reset: Result_q=%08h Result=%08h expected 00000000/40C00000", Result_q, Result);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (Result_q !== 32'h40C0_0000) begin
            n_fail++; $display("FAIL b2b_release: Result_q=%08h expected 40C00000", Result_q);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ALUControl = 1'b0; a = 32'h0; b = 32'h0;
        test_reset();
        test_add();
        test_mul();
        test_specials();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
